// File: rtl/cphy_slave_pkg.sv
// Shared definitions for the C-PHY slave datapath: load-arbiter FSM states and
// default widths/counts shared with the slave data register stage.
package cphy_slave_pkg;

  // Width of the slave data register stage.
  localparam int unsigned DataWidth = 7;

  // Default number of idle cycles after a register load before the next grant.
  localparam int unsigned SettleCyc = 2;

  // Default settle counter width; 2**SettleCntW must exceed the settle count.
  localparam int unsigned SettleCntW = 4;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLoad   = 2'd1,
    StSettle = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter, purely combinational. The priority pointer is
// owned by the parent so it only moves on an accepted transfer.
module rr_arb2 (
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic prio_i,      // requester that wins a tie
  output logic winner_o,    // 0: requester 0, 1: requester 1
  output logic gnt_valid_o  // at least one requester is valid
);

  // A lone requester always wins; on a tie the pointer decides.
  always_comb begin
    gnt_valid_o = valid0_i | valid1_i;
    if (valid0_i && valid1_i) begin
      winner_o = prio_i;
    end else begin
      winner_o = valid1_i;
    end
  end

endmodule

// File: rtl/reg_load_arbiter.sv
// Shares the slave data register stage between two requesters. Grants
// round-robin from IDLE, strobes the winning word into the register stage for
// one cycle, then holds off further grants for a programmable settle window.
module reg_load_arbiter
  import cphy_slave_pkg::*;
#(
  parameter int unsigned WIDTH      = DataWidth,
  parameter int unsigned SETTLE_CYC = SettleCyc,
  parameter int unsigned CNT_W      = SettleCntW  // 2**CNT_W must exceed SETTLE_CYC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic [WIDTH-1:0] reg_data,
  output logic             reg_load,
  output logic             grant_id,
  output logic             busy
);

  // Counter start value on entry to SETTLE; the SETTLE state is skipped when
  // the window is zero, so the zero case value is never used.
  localparam logic [CNT_W-1:0] SettleInit = CNT_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             gid_q, gid_d;
  logic             prio_q, prio_d;

  logic arb_winner;
  logic arb_gnt;
  logic accept;

  rr_arb2 u_arb (
    .valid0_i    (req0_valid),
    .valid1_i    (req1_valid),
    .prio_i      (prio_q),
    .winner_o    (arb_winner),
    .gnt_valid_o (arb_gnt)
  );

  // Ready only in IDLE, only for the winner; gated by reset so nothing is
  // accepted in a reset cycle.
  always_comb begin
    accept     = rst_n && (state_q == StIdle) && arb_gnt;
    req0_ready = accept && !arb_winner;
    req1_ready = accept && arb_winner;
    reg_data   = data_q;
    grant_id   = gid_q;
    reg_load   = (state_q == StLoad);
    busy       = (state_q != StIdle);
  end

  // Next-state logic: capture on accept, one LOAD cycle, then settle countdown.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    gid_d   = gid_q;
    prio_d  = prio_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          data_d  = arb_winner ? req1_data : req0_data;
          gid_d   = arb_winner;
          prio_d  = ~arb_winner;  // the other requester wins the next tie
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (SETTLE_CYC > 0) begin
          cnt_d   = SettleInit;
          state_d = StSettle;
        end else begin
          state_d = StIdle;
        end
      end
      StSettle: begin
        // Exit on zero so the counter never wraps.
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      data_q  <= '0;
      gid_q   <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      gid_q   <= gid_d;
      prio_q  <= prio_d;
    end
  end

endmodule
